// File: rtl/decode_pkg.sv
// ---------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the decode stage: RV32 opcode constants, the 4-bit
// ALU operation encoding seen by EX, the immediate-format enum, the bundle of
// control bits carried through ID/EX, and a helper that extracts the 32-bit
// sign-extended immediate for a given format.
// ---------------------------------------------------------------------------
package decode_pkg;

    // Width of every architectural register index field in the instruction.
    localparam int REG_IDX_W = 5;

    // Major opcodes (instr[6:0]) understood by the decoder.
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SLL   = 4'b0101,
        ALU_SRL   = 4'b0110,
        ALU_SRA   = 4'b0111,
        ALU_SLT   = 4'b1000,
        ALU_SLTU  = 4'b1001,
        ALU_PASSB = 4'b1010
    } alu_op_e;

    // IMM_NONE covers R-type and unknown opcodes: the immediate is zero.
    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

    typedef struct packed {
        alu_op_e aluOp;
        logic    aluSrc;
        logic    memRead;
        logic    memWrite;
        logic    memToReg;
        logic    regWrite;
        logic    branch;
        logic    jump;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '{aluOp: ALU_ADD, default: 1'b0};

    // ALU op for OP / OP-IMM by funct3; alt selects SUB / SRA.
    function automatic alu_op_e arithOp(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // 32-bit sign-extended immediate; callers widen to XLEN.
    function automatic logic [31:0] buildImm(input logic [31:0] ins, input imm_type_e t);
        logic [31:0] imm;
        case (t)
            IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
            IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   imm = {ins[31:12], 12'b0};
            IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_pipe_regfile.sv
// ---------------------------------------------------------------------------
// regfile
// NREGS x XLEN architectural register file: two asynchronous read ports and
// one synchronous write port. x0 always reads zero and ignores writes, as do
// indices beyond NREGS.
// Optional feature: DECODE_WB_BYPASS_EN -- when defined, a read of the
// register being written this cycle returns the write data directly.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset (clears all)
//   i_raddr1/i_raddr2   read indices
//   o_rdata1/o_rdata2   read data
//   i_we/i_waddr/i_wdata write port
// ---------------------------------------------------------------------------
module regfile
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] i_raddr1,
    input  logic [REG_IDX_W-1:0] i_raddr2,
    output logic [XLEN-1:0]      o_rdata1,
    output logic [XLEN-1:0]      o_rdata2,
    input  logic                 i_we,
    input  logic [REG_IDX_W-1:0] i_waddr,
    input  logic [XLEN-1:0]      i_wdata
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_wrEn;

    assign w_wrEn = i_we && (i_waddr != '0) && (int'(i_waddr) < NREGS);

    // A single read port: zero for x0 and out-of-range indices, otherwise
    // the stored value (or the in-flight write data when bypass is built in).
    function automatic logic [XLEN-1:0] readPort(input logic [REG_IDX_W-1:0] a);
        logic [XLEN-1:0] v;
        if (a == '0 || int'(a) >= NREGS) begin
            v = '0;
        end else begin
            v = r_regs[a[AW-1:0]];
`ifdef DECODE_WB_BYPASS_EN
            if (w_wrEn && (i_waddr == a)) begin
                v = i_wdata;
            end
`endif
        end
        return v;
    endfunction

    // Both read ports are purely combinational so decode sees operands in
    // the same cycle the instruction is presented.
    always_comb begin
        o_rdata1 = readPort(i_raddr1);
        o_rdata2 = readPort(i_raddr2);
    end

    // Reset wipes the whole file and beats any write in the same cycle;
    // otherwise writeback lands whenever enabled, regardless of pipeline
    // stall/flush state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wrEn) begin
            r_regs[i_waddr[AW-1:0]] <= i_wdata;
        end
    end

endmodule

// File: rtl/decode_pipe.sv
// ---------------------------------------------------------------------------
// decode_pipe
// RV32I/RV32E instruction decode stage with register-file read and the ID/EX
// pipeline register. Detects load-use hazards against the instruction in
// ID/EX and inserts a bubble while IF holds the dependent instruction.
// Optional feature: DECODE_WB_BYPASS_EN (handled inside regfile).
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   i_in_valid, i_instr, i_pc  instruction from IF
//   i_stall                    hold ID/EX
//   i_flush                    kill instruction being decoded
//   i_wb_we/i_wb_rd/i_wb_data  register-file write port
//   o_hazard_stall             combinational load-use stall request to IF
//   o_ex_*                     registered ID/EX contents
// ---------------------------------------------------------------------------
module decode_pipe
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_in_valid,
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic            i_wb_we,
    input  logic [4:0]      i_wb_rd,
    input  logic [XLEN-1:0] i_wb_data,
    output logic            o_hazard_stall,
    output logic            o_ex_valid,
    output logic [3:0]      o_ex_alu_op,
    output logic            o_ex_alu_src,
    output logic            o_ex_mem_read,
    output logic            o_ex_mem_write,
    output logic            o_ex_mem_to_reg,
    output logic            o_ex_reg_write,
    output logic            o_ex_branch,
    output logic            o_ex_jump,
    output logic            o_ex_illegal,
    output logic [XLEN-1:0] o_ex_rs1_data,
    output logic [XLEN-1:0] o_ex_rs2_data,
    output logic [XLEN-1:0] o_ex_imm,
    output logic [XLEN-1:0] o_ex_pc,
    output logic [4:0]      o_ex_rs1,
    output logic [4:0]      o_ex_rs2,
    output logic [4:0]      o_ex_rd
);

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [4:0]      w_rs1, w_rs2, w_rd;
    ctrl_t           w_ctrl, w_ctrlFinal;
    imm_type_e       w_immType;
    logic            w_useRs1, w_useRs2, w_useRd;
    logic            w_badOpcode, w_badIndex, w_illegal;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_rs1Data, w_rs2Data;
    logic            w_hazard, w_bubble;

    ctrl_t           r_exCtrl;
    logic            r_exValid, r_exIllegal;
    logic [XLEN-1:0] r_exRs1Data, r_exRs2Data, r_exImm, r_exPc;
    logic [4:0]      r_exRs1, r_exRs2, r_exRd;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_rs1    = i_instr[19:15];
    assign w_rs2    = i_instr[24:20];
    assign w_rd     = i_instr[11:7];

    regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_raddr1 (w_rs1),
        .i_raddr2 (w_rs2),
        .o_rdata1 (w_rs1Data),
        .o_rdata2 (w_rs2Data),
        .i_we     (i_wb_we),
        .i_waddr  (i_wb_rd),
        .i_wdata  (i_wb_data)
    );

    // Main decoder: maps the opcode to control bits, the immediate format
    // and which register fields the instruction actually uses. Branches use
    // SUB for equality tests and SLT/SLTU for the ordered compares; jumps
    // and address calculations use ADD with the immediate operand.
    always_comb begin
        w_ctrl      = CTRL_NONE;
        w_immType   = IMM_NONE;
        w_useRs1    = 1'b0;
        w_useRs2    = 1'b0;
        w_useRd     = 1'b0;
        w_badOpcode = 1'b0;
        case (w_opcode)
            OPC_LUI: begin
                w_ctrl.aluOp = ALU_PASSB; w_ctrl.aluSrc = 1'b1; w_ctrl.regWrite = 1'b1;
                w_immType = IMM_U; w_useRd = 1'b1;
            end
            OPC_AUIPC: begin
                w_ctrl.aluSrc = 1'b1; w_ctrl.regWrite = 1'b1;
                w_immType = IMM_U; w_useRd = 1'b1;
            end
            OPC_JAL: begin
                w_ctrl.aluSrc = 1'b1; w_ctrl.jump = 1'b1; w_ctrl.regWrite = 1'b1;
                w_immType = IMM_J; w_useRd = 1'b1;
            end
            OPC_JALR: begin
                w_ctrl.aluSrc = 1'b1; w_ctrl.jump = 1'b1; w_ctrl.regWrite = 1'b1;
                w_immType = IMM_I; w_useRs1 = 1'b1; w_useRd = 1'b1;
            end
            OPC_BRANCH: begin
                w_ctrl.aluOp  = !w_funct3[2] ? ALU_SUB : (w_funct3[1] ? ALU_SLTU : ALU_SLT);
                w_ctrl.branch = 1'b1;
                w_immType = IMM_B; w_useRs1 = 1'b1; w_useRs2 = 1'b1;
            end
            OPC_LOAD: begin
                w_ctrl.aluSrc = 1'b1; w_ctrl.memRead = 1'b1; w_ctrl.memToReg = 1'b1;
                w_ctrl.regWrite = 1'b1;
                w_immType = IMM_I; w_useRs1 = 1'b1; w_useRd = 1'b1;
            end
            OPC_STORE: begin
                w_ctrl.aluSrc = 1'b1; w_ctrl.memWrite = 1'b1;
                w_immType = IMM_S; w_useRs1 = 1'b1; w_useRs2 = 1'b1;
            end
            OPC_OPIMM: begin
                w_ctrl.aluOp = arithOp(w_funct3, (w_funct3 == 3'b101) && i_instr[30]);
                w_ctrl.aluSrc = 1'b1; w_ctrl.regWrite = 1'b1;
                w_immType = IMM_I; w_useRs1 = 1'b1; w_useRd = 1'b1;
            end
            OPC_OP: begin
                w_ctrl.aluOp = arithOp(w_funct3, i_instr[30]);
                w_ctrl.regWrite = 1'b1;
                w_useRs1 = 1'b1; w_useRs2 = 1'b1; w_useRd = 1'b1;
            end
            default: w_badOpcode = 1'b1;
        endcase
    end

    // RV32E only has x0..x15, so any used index with bit 4 set is illegal.
    assign w_badIndex  = (NREGS < 32) &&
                         ((w_useRs1 && w_rs1[4]) || (w_useRs2 && w_rs2[4]) || (w_useRd && w_rd[4]));
    assign w_illegal   = w_badOpcode || w_badIndex;
    assign w_ctrlFinal = w_illegal ? CTRL_NONE : w_ctrl;

    assign w_imm32 = buildImm(i_instr, w_immType);
    assign w_imm   = XLEN'($signed(w_imm32));

    // Load-use: the load in ID/EX cannot forward in time, so the dependent
    // instruction must wait one cycle. Suppressed under stall/flush since
    // those already decide what ID/EX does this edge.
    assign w_hazard = !i_stall && !i_flush && i_in_valid &&
                      r_exValid && r_exCtrl.memRead && (r_exRd != 5'd0) &&
                      ((w_useRs1 && (w_rs1 == r_exRd)) || (w_useRs2 && (w_rs2 == r_exRd)));
    assign o_hazard_stall = w_hazard;

    assign w_bubble = i_flush || (!i_stall && (w_hazard || !i_in_valid));

    // ID/EX register. Reset and bubbles clear everything; a stall holds the
    // current contents; otherwise the freshly decoded instruction is loaded.
    // Illegal instructions still enter with valid set so EX can trap.
    always_ff @(posedge clk) begin
        if (!rst_n || w_bubble) begin
            r_exValid   <= 1'b0;
            r_exCtrl    <= CTRL_NONE;
            r_exIllegal <= 1'b0;
            r_exRs1Data <= '0;
            r_exRs2Data <= '0;
            r_exImm     <= '0;
            r_exPc      <= '0;
            r_exRs1     <= '0;
            r_exRs2     <= '0;
            r_exRd      <= '0;
        end else if (!i_stall) begin
            r_exValid   <= 1'b1;
            r_exCtrl    <= w_ctrlFinal;
            r_exIllegal <= w_illegal;
            r_exRs1Data <= w_rs1Data;
            r_exRs2Data <= w_rs2Data;
            r_exImm     <= w_imm;
            r_exPc      <= i_pc;
            r_exRs1     <= w_rs1;
            r_exRs2     <= w_rs2;
            r_exRd      <= w_rd;
        end
    end

    assign o_ex_valid      = r_exValid;
    assign o_ex_alu_op     = r_exCtrl.aluOp;
    assign o_ex_alu_src    = r_exCtrl.aluSrc;
    assign o_ex_mem_read   = r_exCtrl.memRead;
    assign o_ex_mem_write  = r_exCtrl.memWrite;
    assign o_ex_mem_to_reg = r_exCtrl.memToReg;
    assign o_ex_reg_write  = r_exCtrl.regWrite;
    assign o_ex_branch     = r_exCtrl.branch;
    assign o_ex_jump       = r_exCtrl.jump;
    assign o_ex_illegal    = r_exIllegal;
    assign o_ex_rs1_data   = r_exRs1Data;
    assign o_ex_rs2_data   = r_exRs2Data;
    assign o_ex_imm        = r_exImm;
    assign o_ex_pc         = r_exPc;
    assign o_ex_rs1        = r_exRs1;
    assign o_ex_rs2        = r_exRs2;
    assign o_ex_rd         = r_exRd;

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter NREGS, default 32, architectural register count; legal values 32 (RV32I) and 16 (RV32E).
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 in_valid  in  1  instr/pc valid from IF.
REQ-006 instr  in  32  instruction word.
REQ-007 pc  in  XLEN  PC of instr.
REQ-008 stall  in  1  downstream hold: ID/EX register keeps its value.
REQ-009 flush  in  1  branch redirect: kill the instruction being decoded.
REQ-010 wb_we / wb_rd / wb_data  in  1 / 5 / XLEN  register-file write port.
REQ-011 hazard_stall  out  1  combinational load-use request to IF.
REQ-012 ex_valid  out  1  ID/EX register holds a live instruction.
REQ-013 ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_branch, ex_jump, ex_illegal  out  4/1/1/1/1/1/1/1/1  registered control.
REQ-014 ex_rs1_data, ex_rs2_data, ex_imm, ex_pc  out  XLEN each  registered operands.
REQ-015 ex_rs1, ex_rs2, ex_rd  out  5 each  registered register indices.

Function
REQ-016 Decode SHALL support LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP; any other opcode SHALL set illegal.
REQ-017 Immediates I/S/B/U/J SHALL be sign-extended to XLEN; R-type imm = 0.
REQ-018 Register x0 SHALL read 0; writes to x0 SHALL be ignored.
REQ-019 With NREGS=16, any used rs1/rs2/rd index >= 16 SHALL set illegal; illegal instructions SHALL enter ID/EX with ex_illegal=1 and all other control bits 0.
REQ-020 Register file: NREGS x XLEN, two async read ports, one synchronous write port.
REQ-021 Latency: one cycle; decoded fields appear on ex_* on the edge after instr is presented.
REQ-022 Load-use: hazard_stall=1 when ex_valid and ex_mem_read and ex_rd!=0 and ex_rd equals a used source (rs1, or rs2 for OP/BRANCH/STORE) of a valid instr.
REQ-023 On hazard_stall, the next ID/EX value SHALL be a bubble (ex_valid=0, all control 0); IF holds instr, so it is re-decoded next cycle.
REQ-024 Update priority per edge: flush (bubble) > stall (hold) > hazard_stall (bubble) > load decoded instr; in_valid=0 loads a bubble.
REQ-025 hazard_stall SHALL be 0 while stall=1 or flush=1.
REQ-026 Register-file writes SHALL occur whenever wb_we=1, independent of stall, flush and hazard.

Reset
REQ-027 On rst_n=0 at a clock edge: all ID/EX outputs 0, ex_valid=0, all registers cleared to 0.
REQ-028 Reset SHALL override stall, flush and wb_we in the same cycle.

Configuration
REQ-029 Macro DECODE_WB_BYPASS_EN defined: a read of register r while wb_we=1 and wb_rd=r (r!=0) SHALL return wb_data in the same cycle.
REQ-030 Macro DECODE_WB_BYPASS_EN undefined: the same read SHALL return the old contents; forwarding is left to the EX stage.

Structure
REQ-031 Package decode_pkg SHALL hold opcode constants, the 4-bit ALU op encoding (ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001, PASSB 1010) and the immediate-type enum.
REQ-032 Sub-module regfile (parameters XLEN, NREGS, contains the bypass logic) SHALL be instantiated once.

Verification
REQ-033 Reset, then add x3,x1,x2 (0x002081b3) -> next edge ex_alu_op=0000, ex_rs1=1, ex_rs2=2, ex_rd=3, ex_reg_write=1, ex_valid=1.
REQ-034 wb_we=1, wb_rd=1, wb_data=5 with addi x1,x0,5 decoded and then add reading x1 -> rs1 data=5 same cycle if bypass defined, else 0 that cycle and 5 the next.
REQ-035 lw x5,0(x1) followed by add x6,x5,x5 -> hazard_stall=1 for exactly one cycle, one bubble (ex_valid=0), then add issues with ex_rd=6.
REQ-036 beq x1,x2,+8 (0x00208463) -> ex_branch=1, ex_alu_op=0001, ex_imm=8; flush asserted with stall=1 -> bubble wins.
REQ-037 NREGS=16, add x17,x1,x2 -> ex_illegal=1, ex_reg_write=0; XLEN=64, addi x1,x0,-1 -> ex_imm=0xFFFFFFFFFFFFFFFF.
